// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port ALU request arbiter/sequencer with response register and F commit (optional ALU_ARB_RR_EN round-robin grant)
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_op,
  input  logic [15:0] req0_src0,
  input  logic [15:0] req0_src1,
  input  logic [15:0] req0_imm,
  input  logic        req0_fwe,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_op,
  input  logic [15:0] req1_src0,
  input  logic [15:0] req1_src1,
  input  logic [15:0] req1_imm,
  input  logic        req1_fwe,
  output logic [5:0]  alu_opcode,
  output logic [15:0] alu_src0,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_imm,
  input  logic [15:0] alu_result,
  input  logic [7:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_flags,
  input  logic        flags_ld,
  input  logic [7:0]  flags_din,
  output logic [7:0]  flags_q,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        grant;
  logic        accept;

  logic [5:0]  op_q;
  logic [15:0] src0_q, src1_q, imm_q;
  logic        fwe_q;
  logic        id_q;
  logic [15:0] rsp_result_q;
  logic [7:0]  rsp_flags_q;
  logic [7:0]  f_q;

`ifdef ALU_ARB_RR_EN
  logic last_q;

  // Round-robin: under contention the port not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (req1_valid)          grant = 1'b1;
  end

  // Last-served pointer moves only when a request is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= 1'b1;
    else if (accept) last_q <= grant;
  end
`else
  // Fixed priority: port 1 is granted only when port 0 is not asking.
  always_comb begin
    grant = !req0_valid && req1_valid;
  end
`endif

  assign req0_ready = (state_q == ST_IDLE) && !grant;
  assign req1_ready = (state_q == ST_IDLE) && grant;
  assign accept     = (state_q == ST_IDLE) && (grant ? req1_valid : req0_valid);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one ALU cycle, then hold the response until it is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Operand registers capture the granted payload; they keep driving the ALU afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      src0_q <= '0;
      src1_q <= '0;
      imm_q  <= '0;
      fwe_q  <= 1'b0;
      id_q   <= 1'b0;
    end else if (accept) begin
      op_q   <= grant ? req1_op   : req0_op;
      src0_q <= grant ? req1_src0 : req0_src0;
      src1_q <= grant ? req1_src1 : req0_src1;
      imm_q  <= grant ? req1_imm  : req0_imm;
      fwe_q  <= grant ? req1_fwe  : req0_fwe;
      id_q   <= grant;
    end
  end

  // Response capture at the end of the EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else if (state_q == ST_EXEC) begin
      rsp_result_q <= alu_result;
      rsp_flags_q  <= alu_flags;
    end
  end

  // Architectural F: a direct load overrides a simultaneous ALU flag commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          f_q <= '0;
    else if (flags_ld)                   f_q <= flags_din;
    else if (state_q == ST_EXEC && fwe_q) f_q <= alu_flags;
  end

  assign alu_opcode = op_q;
  assign alu_src0   = src0_q;
  assign alu_src1   = src1_q;
  assign alu_imm    = imm_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign flags_q    = f_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-port arbiter for the core's single shared ALU instance. The execute stage (port 0) and the block-instruction microsequencer (port 1) each present a complete ALU operation over a valid/ready handshake. The arbiter grants one requester and drives the registered operands into the ALU for one cycle. It then captures Result/Flags into a response register and commits flags into the architectural F register. The ALU itself stays purely combinational; all sequencing lives here.

## Interface
Parameters:
- none (datapath widths are fixed: opcode 6, operands 16, flags 8)

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  operation request
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  6  ALU opcode
- req0_src0, req0_src1, req0_imm / req1_src0, req1_src1, req1_imm  in  16 each  operands
- req0_fwe / req1_fwe  in  1  commit the ALU flags to F
- alu_opcode  out  6  to ALU opcode
- alu_src0, alu_src1, alu_imm  out  16 each  to ALU operands
- alu_result  in  16  from ALU Result
- alu_flags  in  8  from ALU Flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  granted port (0/1)
- rsp_result  out  16  captured result
- rsp_flags  out  8  captured flags
- flags_ld  in  1  direct F load (POP AF and similar)
- flags_din  in  8  data for flags_ld
- flags_q  out  8  architectural F register
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: reqN_ready is combinational, equal to (state==IDLE && grant==N).
  - IDLE→EXEC: on any accepted request. The edge captures op, src0, src1, imm, fwe and id into operand registers.
  - EXEC: the operand registers drive the alu_* outputs. EXEC→RESP is unconditional. That edge loads rsp_result←alu_result and rsp_flags←alu_flags. If the captured fwe is 1, the same edge also loads flags_q←alu_flags.
  - RESP: rsp_valid=1. RESP→IDLE on rsp_valid && rsp_ready.
- alu_* outputs always reflect the operand registers. They hold their last values outside EXEC.
- Grant without macro: fixed priority, port 0 wins when both are valid.
- Only one request is accepted per IDLE cycle. The losing requester keeps valid high and its payload stable until it is accepted.
- Flags precedence:
  - flags_ld=1 loads flags_q←flags_din in any state.
  - If flags_ld coincides with the EXEC→RESP fwe commit, flags_ld wins.
- No arithmetic is performed here. Widths pass straight through.

## Timing
- Reset values: state=IDLE, operand registers 0 (so alu_* outputs = 0), rsp_valid=0, rsp_id=0, rsp_result=0x0000, rsp_flags=0x00, flags_q=0x00, busy=0.
- reqN_ready in IDLE is a function of request valids and state only; it never depends on rsp_ready.
- Cycle numbering from an accept at the edge ending cycle T:
  - T+1: EXEC
  - T+2: rsp_valid=1, and the flags_q update is visible
- Minimum issue interval is 3 cycles, because the next accept is possible in the cycle after the response handshake.
- rsp_* hold stable while rsp_valid && !rsp_ready. Both ready outputs stay 0 until the response completes.
- Reset asserted mid-operation, in any state: immediate return to the reset values. The in-flight response is discarded and no partial flag commit occurs.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin grant using a 1-bit last-served pointer.
  - When both requests are valid, the port not served last wins. If only one is valid, it wins.
  - The pointer resets to 1, so port 0 wins the first contention.
  - The pointer updates only on an accept.
- ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins. No pointer register exists.

## Test plan
- req0 op=ADD, src0=0x0012, src1=0x0034, fwe=1; ALU model returns 0x0046 / 0x00 → rsp_valid at T+2 with rsp_id=0, rsp_result=0x0046, flags_q=0x00 at T+2.
- Both valid continuously, 4 ops per port, rsp_ready=1:
  - macro off → grant order 0,0,0,0,1,1,1,1
  - macro on → grant order 0,1,0,1,0,1,0,1
- rsp_ready held low 5 cycles after rsp_valid → rsp_result, rsp_flags and rsp_id stable; req0_ready=req1_ready=0; completion on the first cycle rsp_ready=1.
- req1 fwe=0 with ALU flags 0x44 → rsp_flags=0x44, flags_q unchanged. Repeat with fwe=1 → flags_q=0x44 at T+2.
- flags_ld=1, flags_din=0xA5 in the EXEC cycle of an fwe=1 op whose flags are 0x44 → flags_q=0xA5, rsp_flags=0x44.
- rst_n pulsed low during EXEC → rsp_valid=0, busy=0, flags_q=0x00 immediately; after release, no response is emitted for the dropped operation.
